// File: rtl/gf_serial_host_if.sv
// Job and result handshake bundle between a host controller and gf_serial_host.
// The master drives jobs and accepts results; the slave is the serial host itself.
interface gf_serial_host_if #(
    parameter int DATA_WIDTH = 32
);
    localparam int GRADE_W = $clog2(DATA_WIDTH) + 1;

    logic                      op_valid;
    logic                      op_ready;
    logic [GRADE_W-1:0]        op_grade;
    logic [DATA_WIDTH:0]       op_poly;
    logic [2*DATA_WIDTH-1:0]   op_reduc;
    logic                      res_valid;
    logic                      res_ready;
    logic [DATA_WIDTH-1:0]     res_data;

    modport master (
        output op_valid, op_grade, op_poly, op_reduc, res_ready,
        input  op_ready, res_valid, res_data
    );

    modport slave (
        input  op_valid, op_grade, op_poly, op_reduc, res_ready,
        output op_ready, res_valid, res_data
    );
endinterface

// File: rtl/gf_serial_host.sv
// Host-side serial driver for the serialised GF reduction wrapper: shifts one job
// out MSB-first on three lines, pulses enable, then shifts the W-bit result back in.
//
// state      | meaning
// -----------+-------------------------------------------------------------
// ST_IDLE    | waiting for a job, op_ready high
// ST_SHIFT   | 2W cycles, one bit per line per cycle, MSB first
// ST_EXEC    | single-cycle enable pulse to the wrapper
// ST_WAIT    | RESULT_LATENCY cycles of wrapper latency
// ST_CAPTURE | W cycles sampling i_serial_in into the result register
// ST_DONE    | result presented until res_ready
module gf_serial_host #(
    parameter int DATA_WIDTH     = 32,
    parameter int RESULT_LATENCY = 2
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    gf_serial_host_if.slave      bus,
    output logic                 o_grade_out,
    output logic                 o_poly_red_out,
    output logic                 o_red_out,
    output logic                 o_enable_out,
    input  logic                 i_serial_in,
    output logic                 o_busy
);
    localparam int W  = DATA_WIDTH;
    localparam int XW = 2 * W;
    localparam int CW = $clog2(XW) + 1;
    localparam int LW = (RESULT_LATENCY > 1) ? $clog2(RESULT_LATENCY) : 1;

    localparam logic [CW-1:0] SHIFT_LAST = CW'(XW - 1);
    localparam logic [CW-1:0] CAP_LAST   = CW'(W - 1);
    localparam logic [LW-1:0] WAIT_LOAD  = (RESULT_LATENCY > 0) ? LW'(RESULT_LATENCY - 1) : '0;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SHIFT,
        ST_EXEC,
        ST_WAIT,
        ST_CAPTURE,
        ST_DONE
    } state_t;

    state_t          r_state;
    logic [XW-1:0]   r_grade_sr;
    logic [XW-1:0]   r_poly_sr;
    logic [XW-1:0]   r_red_sr;
    logic [CW-1:0]   r_bit_cnt;
    logic [LW-1:0]   r_wait_cnt;
    logic [W-1:0]    r_res;
    logic            r_op_ready;
    logic            r_busy;
    logic            r_res_valid;
    logic            r_enable;

    logic            w_accept;

    assign w_accept = bus.op_valid & r_op_ready;

    // The shift registers empty themselves with zero fill, so their MSBs are the
    // serial lines directly and read 0 everywhere outside SHIFT.
    assign o_grade_out    = r_grade_sr[XW-1];
    assign o_poly_red_out = r_poly_sr[XW-1];
    assign o_red_out      = r_red_sr[XW-1];
    assign o_enable_out   = r_enable;
    assign o_busy         = r_busy;
    assign bus.op_ready   = r_op_ready;
    assign bus.res_valid  = r_res_valid;
    assign bus.res_data   = r_res;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state     <= ST_IDLE;
            r_grade_sr  <= '0;
            r_poly_sr   <= '0;
            r_red_sr    <= '0;
            r_bit_cnt   <= '0;
            r_wait_cnt  <= '0;
            r_res       <= '0;
            r_op_ready  <= 1'b1;
            r_busy      <= 1'b0;
            r_res_valid <= 1'b0;
            r_enable    <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_grade_sr <= XW'(bus.op_grade);
                        r_poly_sr  <= XW'(bus.op_poly);
                        r_red_sr   <= bus.op_reduc;
                        r_bit_cnt  <= '0;
                        r_op_ready <= 1'b0;
                        r_busy     <= 1'b1;
                        r_state    <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    r_grade_sr <= {r_grade_sr[XW-2:0], 1'b0};
                    r_poly_sr  <= {r_poly_sr[XW-2:0], 1'b0};
                    r_red_sr   <= {r_red_sr[XW-2:0], 1'b0};
                    if (r_bit_cnt == SHIFT_LAST) begin
                        r_bit_cnt <= '0;
                        r_enable  <= 1'b1;
                        r_state   <= ST_EXEC;
                    end else begin
                        r_bit_cnt <= r_bit_cnt + 1'b1;
                    end
                end
                ST_EXEC: begin
                    r_enable   <= 1'b0;
                    r_bit_cnt  <= '0;
                    r_wait_cnt <= WAIT_LOAD;
                    r_state    <= (RESULT_LATENCY == 0) ? ST_CAPTURE : ST_WAIT;
                end
                ST_WAIT: begin
                    if (r_wait_cnt == '0) begin
                        r_state <= ST_CAPTURE;
                    end else begin
                        r_wait_cnt <= r_wait_cnt - 1'b1;
                    end
                end
                ST_CAPTURE: begin
                    r_res <= {r_res[W-2:0], i_serial_in};
                    if (r_bit_cnt == CAP_LAST) begin
                        r_bit_cnt   <= '0;
                        r_res_valid <= 1'b1;
                        r_state     <= ST_DONE;
                    end else begin
                        r_bit_cnt <= r_bit_cnt + 1'b1;
                    end
                end
                ST_DONE: begin
                    if (bus.res_ready) begin
                        r_res_valid <= 1'b0;
                        r_op_ready  <= 1'b1;
                        r_busy      <= 1'b0;
                        r_state     <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_gf_serial_host.sv
// Directed bench for gf_serial_host at W=8: one instance with latency 2 for the
// single-job, backpressure and abort cases, one with latency 0 for back-to-back jobs.
module tb_gf_serial_host;
    logic clk;
    logic rst;

    logic g0, p0, r0, en0, sin0, busy0;
    logic g1, p1, r1, en1, sin1, busy1;

    int total = 0;
    int bad   = 0;

    gf_serial_host_if #(.DATA_WIDTH(8)) if0 ();
    gf_serial_host_if #(.DATA_WIDTH(8)) if1 ();

    gf_serial_host #(.DATA_WIDTH(8), .RESULT_LATENCY(2)) dut0 (
        .i_clk          (clk),
        .i_reset        (rst),
        .bus            (if0.slave),
        .o_grade_out    (g0),
        .o_poly_red_out (p0),
        .o_red_out      (r0),
        .o_enable_out   (en0),
        .i_serial_in    (sin0),
        .o_busy         (busy0)
    );

    gf_serial_host #(.DATA_WIDTH(8), .RESULT_LATENCY(0)) dut1 (
        .i_clk          (clk),
        .i_reset        (rst),
        .bus            (if1.slave),
        .o_grade_out    (g1),
        .o_poly_red_out (p1),
        .o_red_out      (r1),
        .o_enable_out   (en1),
        .i_serial_in    (sin1),
        .o_busy         (busy1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic sin;
        logic red;
        logic poly;
        logic grade;
        logic en;
        logic vld;
    } vec_t;

    vec_t tbl [1:28];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] red_seq;
        logic [15:0] poly_seq;
        logic [15:0] grade_seq;
        logic [7:0]  res_seq;
        logic [7:0]  pat_a;
        logic [7:0]  pat_b;
        logic        seen;
        int          acc2;

        red_seq   = 16'b1010_0101_1100_0011;
        poly_seq  = 16'b0000_0001_0001_1011;
        grade_seq = 16'b0000_0000_0000_1000;
        res_seq   = 8'b1100_1010;
        for (int c = 1; c <= 28; c++) begin
            tbl[c].red   = (c <= 16) ? red_seq[16-c]   : 1'b0;
            tbl[c].poly  = (c <= 16) ? poly_seq[16-c]  : 1'b0;
            tbl[c].grade = (c <= 16) ? grade_seq[16-c] : 1'b0;
            tbl[c].en    = (c == 17);
            tbl[c].vld   = (c == 28);
            tbl[c].sin   = (c >= 20 && c <= 27) ? res_seq[27-c] : 1'b0;
        end

        // Reset held with a job offered
        rst = 1'b1;
        sin0 = 1'b0; sin1 = 1'b0;
        if0.op_valid = 1'b1; if0.op_grade = 4'h8; if0.op_poly = 9'h11B;
        if0.op_reduc = 16'hA5C3; if0.res_ready = 1'b0;
        if1.op_valid = 1'b0; if1.op_grade = '0; if1.op_poly = '0;
        if1.op_reduc = '0; if1.res_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            @(negedge clk);
            chk($sformatf("rst op_ready %0d", i), if0.op_ready, 1);
            chk($sformatf("rst busy %0d", i), busy0, 0);
            chk($sformatf("rst lines %0d", i), {g0, p0, r0, en0, if0.res_valid}, 0);
        end
        chk("rst res_data", if0.res_data, 0);
        rst = 1'b0;
        if0.op_valid = 1'b0;
        @(negedge clk);
        chk("post-rst no accept", {if0.op_ready, busy0}, 2'b10);

        // Single job on the latency-2 instance
        if0.op_valid = 1'b1;
        @(posedge clk);
        for (int c = 1; c <= 28; c++) begin
            @(negedge clk);
            if (c == 1) begin
                if0.op_valid = 1'b0;
                if0.op_grade = 4'h3; if0.op_poly = 9'h1FF; if0.op_reduc = 16'h0F0F;
            end
            sin0 = tbl[c].sin;
            chk($sformatf("red c%0d", c), r0, tbl[c].red);
            chk($sformatf("poly c%0d", c), p0, tbl[c].poly);
            chk($sformatf("grade c%0d", c), g0, tbl[c].grade);
            chk($sformatf("enable c%0d", c), en0, tbl[c].en);
            chk($sformatf("res_valid c%0d", c), if0.res_valid, tbl[c].vld);
            chk($sformatf("op_ready c%0d", c), if0.op_ready, 0);
        end
        chk("res_data", if0.res_data, 8'hCA);

        // Backpressure in DONE
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk($sformatf("bp valid %0d", i), if0.res_valid, 1);
            chk($sformatf("bp data %0d", i), if0.res_data, 8'hCA);
            chk($sformatf("bp op_ready %0d", i), if0.op_ready, 0);
        end
        if0.res_ready = 1'b1;
        @(negedge clk);
        if0.res_ready = 1'b0;
        chk("release op_ready", if0.op_ready, 1);
        chk("release valid", if0.res_valid, 0);
        chk("release busy", busy0, 0);
        chk("release data held", if0.res_data, 8'hCA);

        // Abort with reset at SHIFT cycle 5
        if0.op_valid = 1'b1; if0.op_grade = 4'h8; if0.op_poly = 9'h11B; if0.op_reduc = 16'hA5C3;
        @(posedge clk);
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk);
            if (c == 1) if0.op_valid = 1'b0;
            if (c == 6) rst = 1'b1;
        end
        @(negedge clk);
        rst = 1'b0;
        chk("abort op_ready", if0.op_ready, 1);
        chk("abort busy", busy0, 0);
        chk("abort lines", {g0, p0, r0, en0}, 0);
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (en0 || if0.res_valid) seen = 1'b1;
        end
        chk("abort no enable/valid", seen, 0);

        // Back-to-back on the latency-0 instance, operands changed right after accept
        pat_a = 8'h5E;
        pat_b = 8'h81;
        acc2 = -1;
        if1.op_valid = 1'b1; if1.op_grade = 4'h8; if1.op_poly = 9'h11B;
        if1.op_reduc = 16'h0001; if1.res_ready = 1'b1;
        @(posedge clk);
        for (int c = 1; c <= 54; c++) begin
            @(negedge clk);
            if (c == 1) if1.op_reduc = 16'h8001;
            sin1 = (c >= 18 && c <= 25) ? pat_a[25-c] :
                   (c >= 45 && c <= 52) ? pat_b[52-c] : 1'b0;
            if (acc2 < 0 && if1.op_ready) acc2 = c;
            if (acc2 >= 0 && c == acc2 + 1) if1.op_valid = 1'b0;
            if (c == 1)  chk("b2b red A first", r1, 0);
            if (c == 16) chk("b2b red A last", r1, 1);
            if (c == 17) chk("b2b enable A", en1, 1);
            if (c == 26) begin
                chk("b2b valid A", if1.res_valid, 1);
                chk("b2b data A", if1.res_data, pat_a);
            end
            if (c == 28) chk("b2b red B first", r1, 1);
            if (c == 53) begin
                chk("b2b valid B", if1.res_valid, 1);
                chk("b2b data B", if1.res_data, pat_b);
            end
            if (c == 54) chk("b2b idle after B", {if1.op_ready, busy1}, 2'b10);
        end
        chk("b2b accept spacing", acc2, 27);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/gf_serial_host.md
Name: gf_serial_host

Overview:
- Host-side serial driver for the serialised GF reduction wrapper.
- Accepts one reduction job as parallel operands over a valid/ready handshake.
- Streams the polynomial grade, reduction polynomial and reduction input, one bit per clock, onto the wrapper's three serial input lines, then pulses the wrapper's enable.
- Waits a fixed latency, shifts the W-bit result back in from the wrapper's serial output, and presents it as a parallel word over a valid/ready handshake.

Parameters:
- DATA_WIDTH, 32: field width W. Grade field is clog2(W)+1 bits, polynomial field is W+1 bits, reduction input is 2W bits, result is W bits.
- RESULT_LATENCY, 2: cycles between the enable pulse and the first valid result bit on serial_in. 0 is legal.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- reset  in  1  synchronous, active-high reset.
- op_valid  in  1  job operands valid.
- op_ready  out  1  block can accept a job (high only in IDLE).
- op_grade  in  clog2(W)+1  polynomial grade.
- op_poly  in  W+1  reduction polynomial.
- op_reduc  in  2W  value to reduce.
- grade_out  out  1  serial grade line to the wrapper.
- poly_red_out  out  1  serial polynomial line to the wrapper.
- red_out  out  1  serial reduction-input line to the wrapper.
- enable_out  out  1  one-cycle start pulse to the wrapper.
- serial_in  in  1  serial result line from the wrapper.
- res_valid  out  1  res_data holds a completed result.
- res_ready  in  1  consumer accepts the result.
- res_data  out  W  captured result.
- busy  out  1  high in every state except IDLE.

Behaviour:
- Reset: state goes to IDLE, all shift registers and counters clear to 0.
  - Outputs after reset: op_ready=1; busy=0; res_valid=0; res_data=0; all serial lines and enable_out=0.
- Reset has priority over every other input in every state. Reset mid-operation aborts the job: no enable pulse and no result are produced, and the job is lost.
- FSM states: IDLE, SHIFT, EXEC, WAIT, CAPTURE, DONE.
- IDLE:
  - Job accept happens at the edge where op_valid and op_ready are both 1.
  - On accept, each operand is zero-extended to 2W bits and loaded into its own shift register; the bit counter is cleared. Next state is SHIFT.
  - While op_valid=0 the block stays in IDLE and drives no activity on any line.
- SHIFT (exactly 2W cycles):
  - In SHIFT cycle k (k = 0..2W-1), each serial line drives bit 2W-1-k of its extended operand. Transmission is MSB-first.
  - All three lines shift simultaneously.
  - Because shorter fields are zero-extended, they are preceded by leading zeros, so the last N bits sent on each line are exactly that field.
  - After the last bit, next state is EXEC.
  - Outside SHIFT, all three serial lines are 0.
- EXEC (1 cycle): enable_out=1. enable_out is 0 in every other state.
  - Next state is WAIT, or CAPTURE directly if RESULT_LATENCY=0.
- WAIT: lasts exactly RESULT_LATENCY cycles, counted by a counter, then moves to CAPTURE.
- CAPTURE (exactly W cycles):
  - On each edge, the result register updates as {res[W-2:0], serial_in}. The first captured bit ends in the MSB.
  - After W samples, next state is DONE.
- DONE:
  - res_valid=1 and res_data is held stable.
  - On an edge with res_ready=1, res_valid drops and the state returns to IDLE. res_data keeps its value until the next capture begins.
- Timing: with the accept edge as cycle 0:
  - SHIFT occupies cycles 1..2W.
  - enable_out is high in cycle 2W+1.
  - res_valid first rises in cycle 3W+2+RESULT_LATENCY.
- Back-to-back jobs:
  - If res_ready=1 while in DONE, op_ready is high in the next cycle. Minimum job interval is 3W+3+RESULT_LATENCY cycles.
  - A new job is never accepted while busy=1.
  - Operand inputs are sampled only at the accept edge; changes on them afterwards have no effect.
- Width arithmetic: the bit counter is clog2(2W)+1 bits wide, sized so the terminal count 2W-1 is reachable without wrap. It wraps only on clear.

Test Plan:
- Reset behaviour: apply reset for 3 cycles with op_valid=1 -> op_ready=1, busy=0, res_valid=0, all serial lines and enable_out=0, and no job is accepted during reset.
- Single job (W=8, LAT=2): op_grade=4'h8, op_poly=9'h11B, op_reduc=16'hA5C3, accepted at cycle 0 ->
  - red_out carries 1,0,1,0,0,1,0,1,1,1,0,0,0,0,1,1 over cycles 1..16.
  - poly_red_out carries seven 0s, then 1,0,0,0,1,1,0,1,1.
  - grade_out carries twelve 0s, then 1,0,0,0.
  - enable_out is high only in cycle 17.
- Result capture (same job): bench drives serial_in with 1,1,0,0,1,0,1,0 in cycles 20..27 -> res_valid rises in cycle 28 with res_data=8'hCA.
- Output backpressure: hold res_ready=0 for 10 cycles in DONE -> res_valid and res_data stay stable and op_ready=0. Then raise res_ready -> op_ready=1 on the next cycle.
- Reset mid-SHIFT: assert reset at SHIFT cycle 5 -> IDLE on the next cycle, and no enable_out pulse or res_valid ever appears for that job.
- Back-to-back with RESULT_LATENCY=0: two jobs with res_ready tied to 1 -> second accept occurs exactly 3W+3 = 27 cycles after the first, and both results are correct.
